alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
// - Registered output stage directly downstream of the combinational ALU.
// - Captures OUT, Zero/oVerflow/Negative/Carry and the opcode in one transfer; decouples with valid/ready.
// - 2-entry skid buffer: in_ready is a pure register, so the ALU path is not combinationally tied to
//   res_ready; full throughput is sustained.
// - Feeds writeback/branch logic; keeps a saturating overflow-event counter.
// PARAMETERS
// - bits_size   32  data width; matches the ALU operand width
// - cntrl_size  4   opcode width (Alu_Cntrl)
// - cnt_size    16  width of the overflow-event counter
// PORTS
// - clk          in   1          single clock, rising edge
// - rst          in   1          asynchronous, active-high reset
// - in_valid     in   1          ALU result valid this cycle
// - in_ready     out  1          stage can accept (registered)
// - Alu_Cntrl    in   cntrl_size opcode that produced the result
// - OUT          in   bits_size  ALU result
// - Zero, oVerflow, Negative, Carry  in  1 each  ALU flags
// - res_valid    out  1          head entry valid
// - res_ready    in   1          consumer accepts head entry
// - res_data     out  bits_size  head result
// - res_flags    out  4          head flags {Zero,oVerflow,Negative,Carry}
// - res_op       out  cntrl_size head opcode
// - res_illegal  out  1          head opcode was 4'b1110/4'b1111
// - ovf_count    out  cnt_size   accepted ADD/SUB transfers with oVerflow=1
// BEHAVIOUR
// Handshake
// - Accept occurs when in_valid & in_ready. Drain occurs when res_valid & res_ready.
// - Once res_valid is asserted, res_* stay stable until drained.
// FSM EMPTY / ONE / FULL
// - EMPTY: accept -> ONE.
// - ONE: accept without drain -> FULL; drain without accept -> EMPTY; both -> ONE.
// - FULL: drain -> ONE. No accept is possible in FULL.
// - in_ready is registered. It is 1 in EMPTY and ONE, and 0 in FULL. It is computed for the next state.
// - Storage: head register plus skid register.
// - On the FULL->ONE drain, the skid entry moves to head in the same edge.
// - Latency: accept in cycle N gives res_valid in cycle N+1 when the stage was empty.
// Opcode rules on capture
// - Illegal ops (4'b1110, 4'b1111): the ALU drives X on these.
//   - data and flags are stored as 0; res_illegal is stored as 1.
//   - The Negative input is ignored; stored Negative is 0.
// - Compare ops (0000-0100): data stored as 0; Zero carries the compare result unchanged.
// - All other ops: data and flags are stored as received.
// ovf_count
// - Increments on accept when op is 0101, 0110 or 0111 and oVerflow=1.
// - Saturates at all-ones; it does not wrap.
// Reset
// - rst asserted at any time, including mid-transfer, drops all buffered entries immediately.
// - Reset values: state=EMPTY, in_ready=0 during reset and 1 on the first clock after release,
//   res_valid=0, res_data=0, res_flags=0, res_op=0, res_illegal=0, ovf_count=0.
// CONFIGURATION
// - Macro ALU_STICKY_FLAGS_EN, defined:
//   - adds input sticky_clr (1 bit) and output sticky_flags (4 bits, {Z,V,N,C}).
//   - sticky_flags is the OR of the flags of every accepted non-illegal entry.
//   - sticky_clr has priority over same-cycle set: the register clears, and that cycle's flags are lost.
//   - Reset value of sticky_flags is 0.
// - Macro undefined: neither port exists; no sticky logic is generated.
// STRUCTURE
// - Shared package alu_pkg:
//   - opcode localparams (OP_EQU .. OP_AND, OP_ADD=4'b0101, OP_ADD2=4'b0110, OP_SUB=4'b0111);
//   - typedef enum logic [1:0] {EMPTY, ONE, FULL} rs_state_t;
//   - typedef struct packed alu_res_t {data, flags, op, illegal}.
// - Sub-module alu_res_capture (combinational): maps raw ALU outputs plus opcode to alu_res_t
//   by the opcode rules above. The FSM, buffers and counter stay in alu_result_stage.
// TESTING
// - Single transfer: reset, then ADD with OUT=32'h0000_0005 and flags 0.
//   -> next cycle res_valid=1, res_data=5, res_op=4'b0101, res_flags=4'b0000.
// - Backpressure: hold res_ready=0 and push 3 entries.
//   -> in_ready=0 after the 2nd accept; the 3rd is held.
//   -> release res_ready: entries drain in order 1,2,3 with no loss or duplication.
// - Streaming: in_valid=1 and res_ready=1 for 100 cycles.
//   -> one result per cycle; in_ready never drops; order is preserved.
// - Illegal/compare: Alu_Cntrl=4'b1111 with OUT=X -> res_data=0, res_flags=0, res_illegal=1.
//   Alu_Cntrl=4'b0001 with Zero=1 -> res_data=0, res_flags=4'b1000.
// - Counter saturation: cnt_size=4, 20 SUB transfers with oVerflow=1 -> ovf_count=4'hF.
// - Reset mid-operation: FULL state, assert rst -> res_valid=0 immediately and the buffered data is lost.
//   With ALU_STICKY_FLAGS_EN: Carry set, then sticky_clr together with a Carry=1 accept -> sticky_flags=0.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared opcodes, buffer state encoding and result record for the
//          ALU result stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // The record widths follow the ALU datapath; the stage parameters default to these.
  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 4;

  localparam logic [ALU_OP_W-1:0] OP_EQU  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] OP_NEQ  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] OP_LT   = 4'b0010;
  localparam logic [ALU_OP_W-1:0] OP_GT   = 4'b0011;
  localparam logic [ALU_OP_W-1:0] OP_AND  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] OP_ADD  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] OP_ADD2 = 4'b0110;
  localparam logic [ALU_OP_W-1:0] OP_SUB  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] OP_ILL0 = 4'b1110;
  localparam logic [ALU_OP_W-1:0] OP_ILL1 = 4'b1111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } rs_state_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] data;
    logic [3:0]            flags;   // {Z,V,N,C}
    logic [ALU_OP_W-1:0]   op;
    logic                  illegal;
  } alu_res_t;

  function automatic logic is_ovf_op(input logic [ALU_OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_ADD2) || (op == OP_SUB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_res_capture.sv
// ============================================================================
// Module : alu_res_capture
// Brief  : Combinational mapping of raw ALU outputs and opcode into the
//          stored result record.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_res_capture
  import alu_pkg::*;
(
  input  logic [ALU_OP_W-1:0]   op,
  input  logic [ALU_DATA_W-1:0] data,
  input  logic                  zero,
  input  logic                  ovf,
  input  logic                  neg,
  input  logic                  carry,
  output alu_res_t              res
);

  always_comb begin
    res    = '0;
    res.op = op;
    if ((op == OP_ILL0) || (op == OP_ILL1)) begin
      // The ALU drives X on these opcodes, so nothing from it is kept.
      res.illegal = 1'b1;
    end else if (op <= OP_AND) begin
      res.flags = {zero, ovf, neg, carry};
    end else begin
      res.data  = data;
      res.flags = {zero, ovf, neg, carry};
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_result_stage.sv
// ============================================================================
// Module : alu_result_stage
// Brief  : Registered 2-entry skid stage behind the ALU with a saturating
//          overflow-event counter. Optional sticky flags: ALU_STICKY_FLAGS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_result_stage
  import alu_pkg::*;
#(
  parameter int bits_size  = ALU_DATA_W,
  parameter int cntrl_size = ALU_OP_W,
  parameter int cnt_size   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [cntrl_size-1:0] Alu_Cntrl,
  input  logic [bits_size-1:0]  OUT,
  input  logic                  Zero,
  input  logic                  oVerflow,
  input  logic                  Negative,
  input  logic                  Carry,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [bits_size-1:0]  res_data,
  output logic [3:0]            res_flags,
  output logic [cntrl_size-1:0] res_op,
  output logic                  res_illegal,
`ifdef ALU_STICKY_FLAGS_EN
  input  logic                  sticky_clr,
  output logic [3:0]            sticky_flags,
`endif
  output logic [cnt_size-1:0]   ovf_count
);

  rs_state_t          state_q, state_d;
  alu_res_t           head_q, head_d;
  alu_res_t           skid_q, skid_d;
  logic               in_ready_q, in_ready_d;
  logic [cnt_size-1:0] ovf_count_q, ovf_count_d;
  alu_res_t           cap;
  logic               accept;
  logic               drain;

  alu_res_capture u_capture (
    .op    (Alu_Cntrl),
    .data  (OUT),
    .zero  (Zero),
    .ovf   (oVerflow),
    .neg   (Negative),
    .carry (Carry),
    .res   (cap)
  );

  assign res_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign drain     = res_valid & res_ready;

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    skid_d      = skid_q;
    ovf_count_d = ovf_count_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = cap;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          head_d = cap;
        end else if (accept) begin
          skid_d  = cap;
          state_d = FULL;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (drain) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Registered ready looks ahead at the state being entered.
    in_ready_d = (state_d != FULL);

    if (accept && is_ovf_op(cap.op) && oVerflow && (ovf_count_q != '1)) begin
      ovf_count_d = ovf_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      ovf_count_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign res_data    = head_q.data;
  assign res_flags   = head_q.flags;
  assign res_op      = head_q.op;
  assign res_illegal = head_q.illegal;
  assign ovf_count   = ovf_count_q;

`ifdef ALU_STICKY_FLAGS_EN
  logic [3:0] sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr) begin
      sticky_d = '0;
    end else if (accept && !cap.illegal) begin
      sticky_d = sticky_q | cap.flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_flags = sticky_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// ============================================================================
// Module : tb_alu_result_stage
// Brief  : Directed table-driven bench for alu_result_stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_result_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Alu_Cntrl;
  logic [31:0] OUT;
  logic        Zero, oVerflow, Negative, Carry;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_flags;
  logic [3:0]  res_op;
  logic        res_illegal;
  logic [3:0]  ovf_count;
`ifdef ALU_STICKY_FLAGS_EN
  logic        sticky_clr;
  logic [3:0]  sticky_flags;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ovf = 0;

  always #5 clk = ~clk;

  alu_result_stage #(
    .bits_size  (32),
    .cntrl_size (4),
    .cnt_size   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Alu_Cntrl   (Alu_Cntrl),
    .OUT         (OUT),
    .Zero        (Zero),
    .oVerflow    (oVerflow),
    .Negative    (Negative),
    .Carry       (Carry),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_flags   (res_flags),
    .res_op      (res_op),
    .res_illegal (res_illegal),
`ifdef ALU_STICKY_FLAGS_EN
    .sticky_clr  (sticky_clr),
    .sticky_flags(sticky_flags),
`endif
    .ovf_count   (ovf_count)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] data;
    logic [3:0]  flg;     // {Z,V,N,C}
    logic [31:0] e_data;
    logic [3:0]  e_flg;
    logic        e_ill;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_seq(input int n, input logic [31:0] base, input int stall, input bit stream);
    int s, r, cyc;
    bit acc, drn;
    s = 0; r = 0; cyc = 0;
    Alu_Cntrl = OP_ADD;
    {Zero, oVerflow, Negative, Carry} = 4'b0000;
    OUT       = base;
    in_valid  = 1'b1;
    res_ready = (stall == 0);
    while (r < n && cyc < n + stall + 20) begin
      @(negedge clk);
      if (stream) chk("stream_in_ready", in_ready, 1);
      if (stall >= 3 && cyc == 2) begin
        chk("bp_in_ready_full", in_ready, 0);
        chk("bp_third_held", s, 2);
      end
      acc = in_valid && in_ready;
      drn = res_valid && res_ready;
      if (drn) begin
        chk("order", res_data, base + r);
        r++;
      end
      @(posedge clk); #1;
      if (acc) s++;
      in_valid  = (s < n);
      OUT       = base + s;
      cyc++;
      res_ready = (cyc >= stall);
    end
    chk("all_drained", r, n);
    if (stream) chk("throughput", cyc, n + 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("no_dup", res_valid, 0);
  endtask

  initial begin
    vecs[0] = '{OP_ADD,  32'h0000_0005, 4'b0000, 32'h0000_0005, 4'b0000, 1'b0};
    vecs[1] = '{OP_ILL1, 32'hxxxx_xxxx, 4'bxxxx, 32'h0000_0000, 4'b0000, 1'b1};
    vecs[2] = '{OP_ILL0, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 4'b0000, 1'b1};
    vecs[3] = '{OP_NEQ,  32'h0000_1234, 4'b1000, 32'h0000_0000, 4'b1000, 1'b0};
    vecs[4] = '{OP_EQU,  32'h0000_00FF, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0};
    vecs[5] = '{OP_SUB,  32'hFFFF_FFFF, 4'b0011, 32'hFFFF_FFFF, 4'b0011, 1'b0};
    vecs[6] = '{4'b1000, 32'h0000_A5A5, 4'b0100, 32'h0000_A5A5, 4'b0100, 1'b0};
    vecs[7] = '{OP_ADD2, 32'h8000_0000, 4'b0110, 32'h8000_0000, 4'b0110, 1'b0};

    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    Alu_Cntrl = '0; OUT = '0; {Zero, oVerflow, Negative, Carry} = 4'b0000;
`ifdef ALU_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_flags", res_flags, 0);
    chk("rst_res_op", res_op, 0);
    chk("rst_res_illegal", res_illegal, 0);
    chk("rst_ovf_count", ovf_count, 0);
`ifdef ALU_STICKY_FLAGS_EN
    chk("rst_sticky", sticky_flags, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Single-transfer vectors
    for (int i = 0; i < NV; i++) begin
      Alu_Cntrl = vecs[i].op;
      OUT       = vecs[i].data;
      {Zero, oVerflow, Negative, Carry} = vecs[i].flg;
      res_ready = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if ((vecs[i].op == OP_ADD || vecs[i].op == OP_ADD2 || vecs[i].op == OP_SUB)
          && vecs[i].flg[2] === 1'b1 && exp_ovf < 15)
        exp_ovf++;
      @(negedge clk);
      chk("vec_res_valid", res_valid, 1);
      chk("vec_res_data", res_data, vecs[i].e_data);
      chk("vec_res_flags", res_flags, vecs[i].e_flg);
      chk("vec_res_op", res_op, vecs[i].op);
      chk("vec_res_illegal", res_illegal, vecs[i].e_ill);
      chk("vec_ovf_count", ovf_count, exp_ovf);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      @(negedge clk);
      chk("vec_drained", res_valid, 0);
    end

    // Backpressure: three entries against a stalled consumer
    @(posedge clk); #1;
    run_seq(3, 32'h0000_0100, 5, 1'b0);

    // Streaming at full rate
    @(posedge clk); #1;
    run_seq(100, 32'h0000_1000, 0, 1'b1);

    // Overflow counter saturation
    @(posedge clk); #1;
    Alu_Cntrl = OP_SUB;
    {Zero, oVerflow, Negative, Carry} = 4'b0100;
    res_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      OUT = k;
      @(posedge clk); #1;
      if (k == 9) chk("ovf_mid", ovf_count, (exp_ovf + 10 > 15) ? 15 : exp_ovf + 10);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("ovf_saturated", ovf_count, 4'hF);
    chk("ovf_stream_empty", res_valid, 0);

    // Reset while FULL
    {Zero, oVerflow, Negative, Carry} = 4'b0000;
    Alu_Cntrl = OP_ADD;
    res_ready = 1'b0;
    in_valid  = 1'b1;
    OUT       = 32'h0000_AAAA;
    @(posedge clk); #1;
    OUT = 32'h0000_BBBB;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_res_valid", res_valid, 1);
    chk("full_in_ready", in_ready, 0);
    chk("full_head", res_data, 32'h0000_AAAA);
    #2 rst = 1'b1;
    #1;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_res_data", res_data, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_ovf", ovf_count, 0);
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_in_ready", in_ready, 1);
    chk("after_rst_lost", res_valid, 0);

`ifdef ALU_STICKY_FLAGS_EN
    // Sticky flags: set Carry, then clear while a Carry=1 entry arrives
    Alu_Cntrl = OP_ADD;
    OUT       = 32'h1;
    {Zero, oVerflow, Negative, Carry} = 4'b0001;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("sticky_set", sticky_flags, 4'b0001);
    sticky_clr = 1'b1;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    sticky_clr = 1'b0;
    chk("sticky_clr_priority", sticky_flags, 4'b0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
